// File: rtl/stopwatch_scan_ctrl.sv
// Stopwatch control FSM, count prescaler and 4-digit multiplexed 7-segment scanner.
// Optional leading-zero blanking enabled by defining LEADING_ZERO_BLANK_EN.
module stopwatch_scan_ctrl #(
    parameter int unsigned TICK_DIV = 100000,
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic [3:0] thousands,
    output logic       count_tick,
    output logic       count_clr,
    output logic       running,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int unsigned TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic        count_tick_q, count_tick_d;
    logic        count_clr_q, count_clr_d;
    logic        running_q, running_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;

    logic [3:0]  digit_c;
    logic        blank_c;
    logic        scan_wrap_c;

    // Note: rst_n is active-high in this codebase.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: clear dominates start.
    always_comb begin
        state_d = state_q;
        if (btn_clear) begin
            state_d = S_IDLE;
        end else if (btn_start) begin
            case (state_q)
                S_IDLE:  state_d = S_RUN;
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control outputs and tick prescaler; prescaler advances on cycles spent in RUN.
    always_comb begin
        tick_cnt_d   = tick_cnt_q;
        count_tick_d = 1'b0;
        count_clr_d  = 1'b0;
        running_d    = (state_d == S_RUN);
        if (btn_clear) begin
            tick_cnt_d  = '0;
            count_clr_d = 1'b1;
        end else if (state_q == S_RUN) begin
            if (tick_cnt_q == TW'(TICK_DIV - 1)) begin
                tick_cnt_d   = '0;
                count_tick_d = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + TW'(1);
            end
        end else if (state_q == S_IDLE) begin
            tick_cnt_d = '0;
        end
    end

    always_comb begin
        case (idx_q)
            2'd0:    digit_c = ones;
            2'd1:    digit_c = tens;
            2'd2:    digit_c = hundreds;
            default: digit_c = thousands;
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Suppress leading zeros above the ones digit.
    always_comb begin
        blank_c = 1'b0;
        case (idx_q)
            2'd3:    blank_c = (thousands == 4'd0);
            2'd2:    blank_c = (thousands == 4'd0) && (hundreds == 4'd0);
            2'd1:    blank_c = (thousands == 4'd0) && (hundreds == 4'd0) && (tens == 4'd0);
            default: blank_c = 1'b0;
        endcase
    end
`else
    assign blank_c = 1'b0;
`endif

    function automatic logic [6:0] decode_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Scanner: free-running slot timer, loads the next digit at each wrap.
    assign scan_wrap_c = (scan_cnt_q == SW'(SCAN_DIV - 1));

    always_comb begin
        scan_cnt_d = scan_cnt_q + SW'(1);
        idx_d      = idx_q;
        an_d       = an_q;
        seg_d      = seg_q;
        if (scan_wrap_c) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
            an_d       = ~(4'b0001 << idx_q);
            seg_d      = blank_c ? 7'b1111111 : decode_seg(digit_c);
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            tick_cnt_q   <= '0;
            count_tick_q <= 1'b0;
            count_clr_q  <= 1'b0;
            running_q    <= 1'b0;
            scan_cnt_q   <= '0;
            idx_q        <= 2'd0;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
        end else begin
            tick_cnt_q   <= tick_cnt_d;
            count_tick_q <= count_tick_d;
            count_clr_q  <= count_clr_d;
            running_q    <= running_d;
            scan_cnt_q   <= scan_cnt_d;
            idx_q        <= idx_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign count_tick = count_tick_q;
    assign count_clr  = count_clr_q;
    assign running    = running_q;
    assign an         = an_q;
    assign seg        = seg_q;

endmodule
